mips_fetch_unit: RTL and testbench
==================================

MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-005 imem_addr  output  32  SHALL carry the word-aligned fetch address; bits [1:0] are always 0.
REQ-006 imem_rdata  input  32  SHALL carry the instruction word; it is valid only when imem_ack=1.
REQ-007 imem_ack  input  1  SHALL mark the read as complete; it is sampled only while imem_req=1.
REQ-008 instr  output  32  SHALL carry the held instruction word to the decoder.
REQ-009 OprCtr  output  6  SHALL equal instr[31:26] (decoder opcode input).
REQ-010 funct  output  6  SHALL equal instr[5:0] (decoder function input).
REQ-011 instr_valid  output  1  SHALL mark instr as valid for consumption.
REQ-012 instr_ready  input  1  SHALL indicate that downstream consumes instr this cycle.
REQ-013 Branch, Jump, Zero  input  1 each  SHALL carry the decoder Branch/Jump outputs and the ALU zero flag, all valid during the consume cycle.
REQ-014 pc  output  32  SHALL carry the address of the held instruction.
REQ-015 retired  output  32  SHALL count consumed instructions.

Function
REQ-016 The FSM SHALL have three states: IDLE, FETCH and HOLD; reset enters IDLE.
REQ-017 IDLE SHALL move to FETCH on the next edge with imem_req=0.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr=pc, both held stable until ack.
REQ-019 FETCH with imem_ack=1 SHALL latch imem_rdata into instr and enter HOLD on the same edge; zero-wait ack (the first FETCH cycle) is legal and gives one cycle of fetch latency.
REQ-020 In HOLD, instr_valid SHALL be 1 and imem_req SHALL be 0; instr and pc SHALL hold until instr_valid&instr_ready.
REQ-021 On consume, the unit SHALL set pc<=next_pc, retired<=retired+1, and return to FETCH.
REQ-022 next_pc SHALL be pc+4 by default.
REQ-023 If Branch&Zero, next_pc SHALL be pc+4+(sign_extend(instr[15:0])<<2).
REQ-024 If Jump, next_pc SHALL be {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-025 Jump SHALL take priority over Branch when both are 1.
REQ-026 All PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-027 The retired counter SHALL wrap at 2^32.
REQ-028 imem_ack while not in FETCH SHALL be ignored; instr SHALL be unchanged.
REQ-029 instr_ready while instr_valid=0 SHALL have no effect.
REQ-030 Branch/Jump/Zero SHALL be ignored outside the consume cycle.

Reset
REQ-031 On rst_n=0, regardless of state, the unit SHALL asynchronously set pc=RESET_PC, instr=0, retired=0, state=IDLE, imem_req=0 and instr_valid=0.
REQ-032 An in-flight fetch aborted by reset SHALL be discarded; the first fetch after release SHALL use RESET_PC.

Structure
REQ-033 A shared package mips_pkg SHALL hold the opcode constants OP_RTYPE=6'b000000, OP_BEQ=6'b000100 and OP_J=6'b000010, the fetch-state typedef, and the RESET_PC default.
REQ-034 next-PC computation SHALL be one combinational sub-module, mips_next_pc, with inputs pc, instr, Branch, Jump and Zero, and output next_pc.

Verification
REQ-035 Reset release, imem returns 32'h2008_0005 with zero-wait ack -> imem_addr=0, then instr_valid=1, OprCtr=6'b001000, pc=0.
REQ-036 Held instr at pc=0x10, imem ack delayed 3 cycles, instr_ready=0 for 4 cycles -> imem_addr stable at 0x10 throughout the wait; instr held until consume; next fetch at 0x14, retired=1.
REQ-037 beq at pc=0x20, imm16=16'hFFFE, Branch=1, Zero=1 -> next fetch at 0x1C; same with Zero=0 -> 0x24.
REQ-038 j at pc=0x4000_0000, target 26'h000_0040 -> next fetch at 0x4000_0100; Jump=1 and Branch=1 together -> jump target wins.
REQ-039 PC 0xFFFF_FFFC consumed sequentially -> next imem_addr=0; spurious ack in HOLD -> instr unchanged.
REQ-040 rst_n=0 during a FETCH wait at 0x80 -> outputs cleared immediately; after release, fetch at RESET_PC; a late ack from the old request is ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch slice: decoder opcodes, fetch FSM
// encoding, reset PC default and immediate helpers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_HOLD  = 2'd2;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Branch displacement in bytes: sign-extended word offset shifted left by 2.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] target26);
        return {pc_plus4[31:28], target26, 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Bus between the fetch unit, instruction memory and the decoder stage.
//
// Handshakes: imem_req/imem_ack -- the fetch unit raises imem_req with a
// stable imem_addr and holds both until it sees imem_ack=1 on a rising edge;
// imem_rdata is only meaningful in that cycle, and ack with req=0 is ignored.
// instr_valid/instr_ready -- instr transfers on every edge where both are 1;
// instr is held unchanged while valid=1 and ready=0, and ready with valid=0
// has no effect.
interface mips_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack,
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack,
        input  instr,
        input  instr_valid,
        output instr_ready
    );

endinterface

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection: sequential, taken branch, or jump.
module mips_next_pc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;
    logic        unused_opcode;

    assign pc_plus4      = pc + 32'd4;
    assign unused_opcode = ^instr[31:26];

    // Jump outranks a taken branch when the decoder asserts both.
    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = jump_target(pc_plus4, instr[25:0]);
        end else if (Branch && Zero) begin
            next_pc = pc_plus4 + branch_offset(instr[15:0]);
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: requests a word from imem, holds it for the decoder
// until consumed, then advances the PC and the retired-instruction count.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_fetch_unit_if.master   bus,
    input  logic                Branch,
    input  logic                Jump,
    input  logic                Zero,
    output logic [5:0]          OprCtr,
    output logic [5:0]          funct,
    output logic [31:0]         pc,
    output logic [31:0]         retired,
    output fetch_state_t        state_dbg
);

    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  instr_q;
    logic [31:0]  next_pc;
    logic         fetch_done;
    logic         consume;

    assign fetch_done = (state == ST_FETCH) && bus.imem_ack;
    assign consume    = (state == ST_HOLD) && bus.instr_ready;

    mips_next_pc u_next_pc (
        .pc      (pc),
        .instr   (instr_q),
        .Branch  (Branch),
        .Jump    (Jump),
        .Zero    (Zero),
        .next_pc (next_pc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = ST_FETCH;
            ST_FETCH: if (bus.imem_ack) state_nxt = ST_HOLD;
            ST_HOLD:  if (bus.instr_ready) state_nxt = ST_FETCH;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Reset discards any in-flight request; a late ack lands in IDLE and is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC_W;
            instr_q <= 32'h0000_0000;
            retired <= 32'h0000_0000;
        end else begin
            state <= state_nxt;
            if (fetch_done) begin
                instr_q <= bus.imem_rdata;
            end
            if (consume) begin
                pc      <= next_pc;
                retired <= retired + 32'd1;
            end
        end
    end

    assign bus.imem_req    = (state == ST_FETCH);
    assign bus.imem_addr   = {pc[31:2], 2'b00};
    assign bus.instr_valid = (state == ST_HOLD);
    assign bus.instr       = instr_q;

    assign OprCtr    = instr_q[31:26];
    assign funct     = instr_q[5:0];
    assign state_dbg = state;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: two instances (RESET_PC 0 and
// 0x4000_0000) share stimulus; sel chooses which one is observed.
module tb_mips_fetch_unit;
  import mips_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ack = 1'b0;
  logic        instr_ready = 1'b0;
  logic        br = 1'b0;
  logic        jp = 1'b0;
  logic        zr = 1'b0;
  logic        sel = 1'b0;

  mips_fetch_unit_if bus_lo ();
  mips_fetch_unit_if bus_hi ();

  assign bus_lo.imem_rdata  = imem_rdata;
  assign bus_lo.imem_ack    = imem_ack;
  assign bus_lo.instr_ready = instr_ready;
  assign bus_hi.imem_rdata  = imem_rdata;
  assign bus_hi.imem_ack    = imem_ack;
  assign bus_hi.instr_ready = instr_ready;

  logic [5:0]   opr_lo, opr_hi, fn_lo, fn_hi;
  logic [31:0]  pc_lo, pc_hi, ret_lo, ret_hi;
  fetch_state_t st_lo, st_hi;

  mips_fetch_unit u_dut_lo (
    .clk(clk), .rst_n(rst_n), .bus(bus_lo),
    .Branch(br), .Jump(jp), .Zero(zr),
    .OprCtr(opr_lo), .funct(fn_lo), .pc(pc_lo), .retired(ret_lo),
    .state_dbg(st_lo)
  );

  mips_fetch_unit #(.RESET_PC(32'h4000_0000)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .bus(bus_hi),
    .Branch(br), .Jump(jp), .Zero(zr),
    .OprCtr(opr_hi), .funct(fn_hi), .pc(pc_hi), .retired(ret_hi),
    .state_dbg(st_hi)
  );

  logic        o_req, o_valid;
  logic [31:0] o_addr, o_instr, o_pc, o_ret;
  logic [5:0]  o_opr, o_fn;
  logic [1:0]  o_state;

  assign o_req   = sel ? bus_hi.imem_req    : bus_lo.imem_req;
  assign o_valid = sel ? bus_hi.instr_valid : bus_lo.instr_valid;
  assign o_addr  = sel ? bus_hi.imem_addr   : bus_lo.imem_addr;
  assign o_instr = sel ? bus_hi.instr       : bus_lo.instr;
  assign o_pc    = sel ? pc_hi  : pc_lo;
  assign o_ret   = sel ? ret_hi : ret_lo;
  assign o_opr   = sel ? opr_hi : opr_lo;
  assign o_fn    = sel ? fn_hi  : fn_lo;
  assign o_state = sel ? st_hi  : st_lo;

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_ret = 32'h0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks (all run from a negedge) ----------------
  task automatic wait_req();
    int n = 0;
    while (!o_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_req) check("req_timeout", 32'(o_req), 32'd1);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                       input int delay, input logic ready_in_wait);
    wait_req();
    check("imem_addr", o_addr, addr);
    for (int i = 0; i < delay; i++) begin
      instr_ready = ready_in_wait;
      @(negedge clk);
      check("addr_stable", o_addr, addr);
      check("req_stable", 32'(o_req), 32'd1);
      check("ret_in_wait", o_ret, exp_ret);
    end
    instr_ready = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'hA5A5_5A5A;
    check("instr_valid", 32'(o_valid), 32'd1);
    check("req_low_hold", 32'(o_req), 32'd0);
    check("instr", o_instr, data);
    check("pc_held", o_pc, addr);
  endtask

  task automatic consume(input logic b, input logic j, input logic z);
    instr_ready = 1'b1;
    br = b;
    jp = j;
    zr = z;
    @(negedge clk);
    instr_ready = 1'b0;
    br = 1'b0;
    jp = 1'b0;
    zr = 1'b0;
    exp_ret = exp_ret + 32'd1;
    check("retired", o_ret, exp_ret);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_req", 32'(o_req), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_pc", o_pc, 32'h0);
    check("rst_ret", o_ret, 32'h0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_state", 32'(o_state), 32'(ST_IDLE));

    // Zero-wait first fetch at 0.
    rst_n = 1'b1;
    fetch(32'h0, 32'h2008_0005, 0, 1'b0);
    check("OprCtr", 32'(o_opr), 32'h08);
    check("funct", 32'(o_fn), 32'h05);
    consume(1'b0, 1'b0, 1'b0);

    // beq at 4 with imm -3 taken: 8 - 12 wraps to 0xFFFF_FFFC.
    fetch(32'h4, 32'h1000_FFFD, 0, 1'b0);
    consume(1'b1, 1'b0, 1'b1);
    fetch(32'hFFFF_FFFC, 32'h0000_0020, 0, 1'b0);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    check("spurious_ack", o_instr, 32'h0000_0020);
    check("spurious_valid", 32'(o_valid), 32'd1);
    consume(1'b0, 1'b0, 1'b0);

    // Sequential wrap to 0; ready during the fetch wait must do nothing.
    fetch(32'h0, 32'h0000_0000, 2, 1'b1);
    consume(1'b0, 1'b0, 1'b0);

    // j target 4 -> 0x10; then delayed ack and a stalled consumer.
    fetch(32'h4, 32'h0800_0004, 0, 1'b0);
    consume(1'b0, 1'b1, 1'b0);
    fetch(32'h10, 32'h0123_4567, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      br = 1'b1;
      jp = 1'b1;
      zr = 1'b1;
      @(negedge clk);
      check("stall_instr", o_instr, 32'h0123_4567);
      check("stall_pc", o_pc, 32'h10);
    end
    br = 1'b0;
    jp = 1'b0;
    zr = 1'b0;
    consume(1'b0, 1'b0, 1'b0);

    // 0x14: j -> 0x20; beq -2 taken -> 0x1C; back to 0x20; beq not taken -> 0x24.
    fetch(32'h14, 32'h0800_0008, 0, 1'b0);
    consume(1'b0, 1'b1, 1'b0);
    fetch(32'h20, 32'h1000_FFFE, 0, 1'b0);
    consume(1'b1, 1'b0, 1'b1);
    fetch(32'h1C, 32'h0800_0008, 1, 1'b0);
    consume(1'b0, 1'b1, 1'b0);
    fetch(32'h20, 32'h1000_FFFE, 0, 1'b0);
    consume(1'b1, 1'b0, 1'b0);
    fetch(32'h24, 32'h0800_0020, 0, 1'b0);
    consume(1'b0, 1'b1, 1'b0);

    // Reset while waiting for ack at 0x80, with a late ack across release.
    wait_req();
    check("addr_80", o_addr, 32'h80);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(o_req), 32'd0);
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_pc", o_pc, 32'h0);
    check("arst_ret", o_ret, 32'h0);
    check("arst_instr", o_instr, 32'h0);
    exp_ret = 32'h0;
    imem_ack = 1'b1;
    imem_rdata = 32'hBADC_0DE0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("late_ack_instr", o_instr, 32'h0);
    check("late_ack_valid", 32'(o_valid), 32'd0);
    check("late_ack_state", 32'(o_state), 32'(ST_FETCH));
    fetch(32'h0, 32'h2008_0005, 0, 1'b0);
    consume(1'b0, 1'b0, 1'b0);
    fetch(32'h4, 32'h0000_0000, 0, 1'b0);

    // High-region instance: jumps keep pc_plus4[31:28]; jump beats branch.
    @(negedge clk);
    sel = 1'b1;
    rst_n = 1'b0;
    exp_ret = 32'h0;
    @(negedge clk);
    check("hi_rst_pc", o_pc, 32'h4000_0000);
    rst_n = 1'b1;
    fetch(32'h4000_0000, 32'h0800_0040, 0, 1'b0);
    consume(1'b0, 1'b1, 1'b0);
    fetch(32'h4000_0100, 32'h0800_0080, 0, 1'b0);
    consume(1'b1, 1'b1, 1'b1);
    fetch(32'h4000_0200, 32'h0000_0000, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
